length_fetch_scheduler: RTL
===========================

LENGTH_FETCH_SCHEDULER -- requirements
Module: length_fetch_scheduler

Interface
REQ-001 Parameter CHANNEL_NUM, default 8, number of length channels/FIFOs served.
REQ-002 Parameter ADDR_W, default 9, ROM address width.
REQ-003 Parameter FIFO_DEPTH, default 16, entries per downstream channel FIFO; sets the credit count.
REQ-004 Parameter ROM_LATENCY, default 1, cycles from rom_addr to valid ROM data.
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 start  in  1  one-cycle pulse; loads base/end addresses and begins fetching.
REQ-008 base_addr  in  CHANNEL_NUM*ADDR_W  first ROM address per channel; channel i at bits [i*ADDR_W +: ADDR_W].
REQ-009 end_addr  in  CHANNEL_NUM*ADDR_W  exclusive end address per channel, same packing.
REQ-010 fifo_rd  in  CHANNEL_NUM  consumer read strobe per FIFO; returns one credit.
REQ-011 rom_addr  out  ADDR_W  address to the shared single-port ROM.
REQ-012 wr_en  out  CHANNEL_NUM  one-hot (or zero) write strobe to the FIFOs, aligned with ROM data.
REQ-013 chan_done  out  CHANNEL_NUM  channel i has issued all its addresses.
REQ-014 busy  out  1  high in RUN and DRAIN.
REQ-015 done  out  1  high in DONE.

Function
REQ-016 FSM states: IDLE, RUN, DRAIN, DONE.
REQ-017 IDLE->RUN on start; IDLE->DONE on start if every base_addr == end_addr.
REQ-018 On start: addr[i] <= base_addr[i], end[i] <= end_addr[i], credit[i] <= FIFO_DEPTH, RR pointer <= 0.
REQ-019 Channel i eligible in RUN iff credit[i] > 0 and addr[i] != end[i].
REQ-020 Each RUN cycle at most one grant: first eligible channel searching upward from (last_grant+1) mod CHANNEL_NUM, wrapping; after start the search begins at channel 0.
REQ-021 On grant to i: rom_addr = addr[i] in the same cycle (registered output, combinational select allowed), addr[i] <= addr[i]+1, credit[i] decremented, last_grant <= i.
REQ-022 wr_en = one-hot(i) exactly ROM_LATENCY cycles after the grant cycle, via a ROM_LATENCY-deep valid/one-hot shift pipeline; never more than one bit set.
REQ-023 No grant cycle: rom_addr holds its last value, nothing enters the pipeline.
REQ-024 Credit update per cycle: grant only -> -1; fifo_rd only -> +1; both on the same channel -> unchanged.
REQ-025 fifo_rd on a channel with credit == FIFO_DEPTH is ignored (saturate, no wrap); credit width = clog2(FIFO_DEPTH+1).
REQ-026 chan_done[i] = (addr[i] == end[i]) while not in IDLE; 0 in IDLE.
REQ-027 RUN->DRAIN when all chan_done bits are set; DRAIN lasts exactly ROM_LATENCY cycles, then ->DONE; wr_en keeps firing in DRAIN for in-flight grants.
REQ-028 DONE->RUN on start (full reload as in REQ-018); start in RUN or DRAIN is ignored.
REQ-029 Addresses wrap modulo 2^ADDR_W; base > end is legal and fetches across the wrap.
REQ-030 fifo_rd is accepted in every state; credits are only (re)initialised by start.

Reset
REQ-031 rst, sampled at a rising edge, forces state IDLE, wr_en = 0, rom_addr = 0, pipeline cleared, addr/end/credit = 0, RR pointer = 0, busy = 0, done = 0, chan_done = 0.
REQ-032 rst mid-RUN/DRAIN discards in-flight grants: no wr_en in any cycle after the reset edge.
REQ-033 rst has priority over start in the same cycle.

Structure
REQ-034 FSM state encoding and the packed-field width constant go in the shared params package; channel base/end defaults in params, not in this module.
REQ-035 One sub-module: rr_arbiter (CHANNEL_NUM-wide request vector, last-grant pointer in, one-hot grant plus index out, purely combinational).
REQ-036 Credit counters, address registers and latency pipeline stay in length_fetch_scheduler.

Verification
REQ-037 CHANNEL_NUM=4, ranges 0..3/10..13/20..23/30..33, no reads -> rom_addr 0,10,20,30,1,11,... one per cycle; wr_en one-hot 1 cycle later; done after 12 grants + 1 drain cycle.
REQ-038 FIFO_DEPTH=2, single channel 0..9, fifo_rd never -> exactly 2 grants then stall; one fifo_rd -> exactly one more grant.
REQ-039 Grant and fifo_rd on the same channel/cycle with credit=1 -> credit stays 1, next-cycle grant still allowed.
REQ-040 Channel 2 base=end=5, others non-empty -> chan_done[2]=1 from first RUN cycle, channel 2 never granted.
REQ-041 rst asserted one cycle after a grant (ROM_LATENCY=2) -> no wr_en afterwards, outputs at reset values; new start reloads cleanly.
REQ-042 ADDR_W=9, base=510, end=2 -> addresses 510,511,0,1 then chan_done.

Source files
------------

// File: rtl/length_fetch_scheduler_pkg.sv
// Shared types and defaults for the length fetch scheduler: FSM encoding,
// packed address-field width and per-channel default ranges.
package length_fetch_scheduler_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam int ADDR_FIELD_W        = 9;
   localparam int DEF_CHANNEL_NUM     = 8;
   localparam int DEF_FIFO_DEPTH      = 16;
   localparam int DEF_ROM_LATENCY     = 1;
   localparam logic [ADDR_FIELD_W-1:0] DEF_CHAN_BASE = '0;
   localparam logic [ADDR_FIELD_W-1:0] DEF_CHAN_END  = '0;

   // Index width that stays legal for a single-entry vector.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/length_fetch_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr_i,
// wrapping, returned as one-hot plus binary index.
module rr_arbiter
   import length_fetch_scheduler_pkg::*;
#(
   parameter int N     = DEF_CHANNEL_NUM,
   parameter int IDX_W = idx_width(DEF_CHANNEL_NUM)
)(
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N-1:0]     gnt_o,
   output logic [IDX_W-1:0] gnt_idx_o,
   output logic             gnt_valid_o
);

   int j;

   always_comb begin
      gnt_o       = '0;
      gnt_idx_o   = '0;
      gnt_valid_o = 1'b0;
      j           = 0;
      for (int k = 0; k < N; k++) begin
         j = int'(ptr_i) + k;
         if (j >= N) begin
            j = j - N;
         end
         if (!gnt_valid_o && req_i[j]) begin
            gnt_valid_o = 1'b1;
            gnt_idx_o   = IDX_W'(j);
            gnt_o[j]    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/length_fetch_scheduler.sv
// Credit-based round-robin ROM fetcher: one address per cycle into a shared
// ROM, write strobes to per-channel FIFOs aligned with ROM read latency.
module length_fetch_scheduler
   import length_fetch_scheduler_pkg::*;
#(
   parameter int CHANNEL_NUM = DEF_CHANNEL_NUM,
   parameter int ADDR_W      = ADDR_FIELD_W,
   parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
   parameter int ROM_LATENCY = DEF_ROM_LATENCY
)(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start,
   input  logic [CHANNEL_NUM*ADDR_W-1:0] base_addr,
   input  logic [CHANNEL_NUM*ADDR_W-1:0] end_addr,
   input  logic [CHANNEL_NUM-1:0]        fifo_rd,
   output logic [ADDR_W-1:0]             rom_addr,
   output logic [CHANNEL_NUM-1:0]        wr_en,
   output logic [CHANNEL_NUM-1:0]        chan_done,
   output logic                          busy,
   output logic                          done
);

   localparam int IDX_W  = idx_width(CHANNEL_NUM);
   localparam int CRED_W = $clog2(FIFO_DEPTH + 1);
   localparam int DCNT_W = $clog2(ROM_LATENCY + 1);
   localparam logic [CRED_W-1:0] CRED_FULL = CRED_W'(FIFO_DEPTH);

   state_e                   state_q;
   logic [ADDR_W-1:0]        addr_q   [CHANNEL_NUM];
   logic [ADDR_W-1:0]        end_q    [CHANNEL_NUM];
   logic [CRED_W-1:0]        credit_q [CHANNEL_NUM];
   logic [CHANNEL_NUM-1:0]   pipe_q   [ROM_LATENCY];
   logic [IDX_W-1:0]         ptr_q;
   logic [ADDR_W-1:0]        rom_addr_q;
   logic [DCNT_W-1:0]        drain_q;
   logic                     busy_q;
   logic                     done_q;

   logic [CHANNEL_NUM-1:0]   req;
   logic [CHANNEL_NUM-1:0]   gnt;
   logic [CHANNEL_NUM-1:0]   at_end;
   logic [CHANNEL_NUM-1:0]   empty_start;
   logic [IDX_W-1:0]         gnt_idx;
   logic                     gnt_valid;
   logic                     load;

   assign load = start && (state_q == ST_IDLE || state_q == ST_DONE);

   for (genvar gi = 0; gi < CHANNEL_NUM; gi++) begin : gen_chan
      assign at_end[gi]      = (addr_q[gi] == end_q[gi]);
      assign req[gi]         = (state_q == ST_RUN) && (credit_q[gi] != '0) && !at_end[gi];
      assign empty_start[gi] = (base_addr[gi*ADDR_W +: ADDR_W] == end_addr[gi*ADDR_W +: ADDR_W]);
   end

   rr_arbiter #(
      .N     (CHANNEL_NUM),
      .IDX_W (IDX_W)
   ) u_arb (
      .req_i       (req),
      .ptr_i       (ptr_q),
      .gnt_o       (gnt),
      .gnt_idx_o   (gnt_idx),
      .gnt_valid_o (gnt_valid)
   );

   // The ROM sees the granted address in the grant cycle; otherwise it holds.
   assign rom_addr  = gnt_valid ? addr_q[gnt_idx] : rom_addr_q;
   assign wr_en     = pipe_q[ROM_LATENCY-1];
   assign chan_done = (state_q == ST_IDLE) ? '0 : at_end;
   assign busy      = busy_q;
   assign done      = done_q;

   always_ff @(posedge clk) begin
      for (int c = 0; c < CHANNEL_NUM; c++) begin
         if (rst) begin
            addr_q[c]   <= '0;
            end_q[c]    <= '0;
            credit_q[c] <= '0;
         end else if (load) begin
            addr_q[c]   <= base_addr[c*ADDR_W +: ADDR_W];
            end_q[c]    <= end_addr[c*ADDR_W +: ADDR_W];
            credit_q[c] <= CRED_FULL;
         end else begin
            if (gnt[c]) begin
               addr_q[c] <= addr_q[c] + 1'b1;
            end
            // A read returning a credit in the grant cycle cancels the spend.
            if (gnt[c] && !fifo_rd[c]) begin
               credit_q[c] <= credit_q[c] - 1'b1;
            end else if (!gnt[c] && fifo_rd[c] && credit_q[c] != CRED_FULL) begin
               credit_q[c] <= credit_q[c] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int s = 0; s < ROM_LATENCY; s++) begin
         if (rst) begin
            pipe_q[s] <= '0;
         end else if (s == 0) begin
            pipe_q[s] <= gnt;
         end else begin
            pipe_q[s] <= pipe_q[s-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         ptr_q      <= '0;
         rom_addr_q <= '0;
         drain_q    <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         if (gnt_valid) begin
            rom_addr_q <= addr_q[gnt_idx];
            ptr_q      <= (gnt_idx == IDX_W'(CHANNEL_NUM - 1)) ? '0 : gnt_idx + 1'b1;
         end
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  ptr_q <= '0;
                  if (&empty_start) begin
                     state_q <= ST_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= ST_RUN;
                     busy_q  <= 1'b1;
                     done_q  <= 1'b0;
                  end
               end
            end
            ST_RUN: begin
               if (&at_end) begin
                  state_q <= ST_DRAIN;
                  drain_q <= DCNT_W'(ROM_LATENCY - 1);
               end
            end
            ST_DRAIN: begin
               if (drain_q == '0) begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  drain_q <= drain_q - 1'b1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule
